// File: rtl/seq_pattern_detector.sv
// seq_pattern_detector
// Serial pattern detector: shifts in one bit per accepted cycle and raises a
// one-cycle registered pulse on y when the last LEN accepted bits equal the
// runtime pattern (bit LEN-1 oldest, bit 0 newest). Overlapping or
// non-overlapping detection is selected per accepted bit by 'overlap'.
// Optional feature: define SEQDET_COUNT_EN to add the match_cnt port and a
// CNT_W-bit saturating match counter (cleared only by reset).
// Reset is synchronous and active-low; clear is a synchronous flush.

module seq_pattern_detector #(
    parameter int LEN   = 4,
    parameter int CNT_W = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           clear,
    input  logic           in_valid,
    input  logic           x,
    input  logic [LEN-1:0] pattern,
    input  logic           overlap,
`ifdef SEQDET_COUNT_EN
    output logic [CNT_W-1:0] match_cnt,
`endif
    output logic           y
);

    // fill counts 0..LEN, so it needs enough bits to hold LEN itself
    localparam int FILL_W = $clog2(LEN + 1);
    localparam logic [FILL_W-1:0] LEN_F  = FILL_W'(LEN);
    localparam logic [FILL_W-1:0] ONE_F  = FILL_W'(1);
    localparam logic [FILL_W-1:0] ARM_AT = LEN_F - ONE_F;

    // ARMED means one more accepted bit completes a full window
    typedef enum logic {
        FILLING = 1'b0,
        ARMED   = 1'b1
    } state_t;

    state_t            state;
    logic [LEN-1:0]    hist;
    logic [FILL_W-1:0] fill;

    logic [LEN-1:0]    next_hist;
    logic              hit;
    logic [FILL_W-1:0] fill_inc;
    logic [FILL_W-1:0] next_fill;

    // Candidate window, match decision and post-accept fill level for this edge
    always_comb begin
        next_hist = {hist[LEN-2:0], x};
        hit       = (state == ARMED) && (next_hist == pattern);
        fill_inc  = (fill == LEN_F) ? LEN_F : (fill + ONE_F);
        next_fill = (hit && !overlap) ? '0 : fill_inc;
    end

    // Detector FSM: history shift, fill tracking and registered match pulse
    always_ff @(posedge clk) begin
        if (!reset) begin
            hist  <= '0;
            fill  <= '0;
            state <= FILLING;
            y     <= 1'b0;
        end else if (clear) begin
            hist  <= '0;
            fill  <= '0;
            state <= FILLING;
            y     <= 1'b0;
        end else if (in_valid) begin
            hist  <= next_hist;
            fill  <= next_fill;
            state <= (next_fill >= ARM_AT) ? ARMED : FILLING;
            y     <= hit;
        end else begin
            y     <= 1'b0;
        end
    end

`ifdef SEQDET_COUNT_EN
    // Saturating match counter; survives clear, only reset zeroes it
    always_ff @(posedge clk) begin
        if (!reset) begin
            match_cnt <= '0;
        end else if (!clear && in_valid && hit && (match_cnt != '1)) begin
            match_cnt <= match_cnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_seq_pattern_detector.sv
// tb_seq_pattern_detector
// Scoreboard bench for seq_pattern_detector. The driver applies directed and
// random cycles and, at each edge, pushes the reference model's expected y
// (and match count when SEQDET_COUNT_EN is defined) into a queue; an
// independent monitor pops one entry per cycle and compares against the DUT.
// The reference model keeps the accepted bits since the last flush as a queue
// and matches when that queue holds LEN bits equal to the pattern.

module tb_seq_pattern_detector;

    localparam int LEN     = 4;
    localparam int CNT_W   = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic           clk;
    logic           reset;
    logic           clear;
    logic           in_valid;
    logic           x;
    logic [LEN-1:0] pattern;
    logic           overlap;
    logic           y;
`ifdef SEQDET_COUNT_EN
    logic [CNT_W-1:0] match_cnt;
`endif

    typedef struct {
        logic y;
        int   cnt;
    } exp_t;

    exp_t exp_q[$];
    bit   bits_q[$];
    int   model_cnt;
    int   checks;
    int   errors;
    int   cycle;

    seq_pattern_detector #(
        .LEN   (LEN),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .in_valid  (in_valid),
        .x         (x),
        .pattern   (pattern),
        .overlap   (overlap),
`ifdef SEQDET_COUNT_EN
        .match_cnt (match_cnt),
`endif
        .y         (y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference behaviour for one clock edge with the inputs currently applied
    task automatic modelEdge();
        exp_t e;
        bit   m;
        m = 1'b0;
        if (!reset) begin
            bits_q.delete();
            model_cnt = 0;
        end else if (clear) begin
            bits_q.delete();
        end else if (in_valid) begin
            bits_q.push_back(x);
            if (bits_q.size() > LEN) void'(bits_q.pop_front());
            if (bits_q.size() == LEN) begin
                m = 1'b1;
                for (int i = 0; i < LEN; i++)
                    if (bits_q[i] != pattern[LEN-1-i]) m = 1'b0;
            end
            if (m) begin
                if (model_cnt < CNT_MAX) model_cnt++;
                if (!overlap) bits_q.delete();
            end
        end
        e.y   = m;
        e.cnt = model_cnt;
        exp_q.push_back(e);
    endtask

    // Drive one cycle of inputs, let the edge happen, record the expectation
    task automatic applyStimulus(input logic rst_n, input logic clr, input logic vld,
                                 input logic bit_in, input logic [LEN-1:0] pat,
                                 input logic ovl);
        reset    = rst_n;
        clear    = clr;
        in_valid = vld;
        x        = bit_in;
        pattern  = pat;
        overlap  = ovl;
        @(posedge clk);
        modelEdge();
        cycle++;
        #1;
    endtask

    // Shift a stream of bits (first element oldest) on consecutive valid cycles
    task automatic sendStream(input logic [31:0] bits, input int n,
                              input logic [LEN-1:0] pat, input logic ovl);
        for (int i = n - 1; i >= 0; i--)
            applyStimulus(1'b1, 1'b0, 1'b1, bits[i], pat, ovl);
    endtask

    task automatic doReset(input logic [LEN-1:0] pat, input logic ovl);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, pat, ovl);
    endtask

    // Compare one popped expectation against what the DUT presents
    task automatic checkOutput(input exp_t e);
        checks++;
        if (y !== e.y) begin
            errors++;
            $display("[TB] FAIL y cycle=%0d actual=%b required=%b", cycle, y, e.y);
        end
`ifdef SEQDET_COUNT_EN
        checks++;
        if (match_cnt !== CNT_W'(e.cnt)) begin
            errors++;
            $display("[TB] FAIL match_cnt cycle=%0d actual=%0d required=%0d",
                     cycle, match_cnt, e.cnt);
        end
`endif
    endtask

    // Monitor: a few ns after each edge, pop the expectation for that edge
    initial begin
        forever begin
            @(posedge clk);
            #3;
            if (exp_q.size() > 0) checkOutput(exp_q.pop_front());
        end
    end

    // Watchdog so the run can never hang
    initial begin
        #500000;
        $display("[TB] FAIL watchdog cycle=%0d actual=running required=finished", cycle);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int wait_cycles;
        logic [LEN-1:0] pat;
        logic ovl;
        checks    = 0;
        errors    = 0;
        cycle     = 0;
        model_cnt = 0;
        reset     = 1'b0;
        clear     = 1'b0;
        in_valid  = 1'b0;
        x         = 1'b0;
        pattern   = '0;
        overlap   = 1'b0;

        // Overlapping 1011 on 1,0,1,1,0,1,1: pulses after bits 4 and 7
        doReset(4'b1011, 1'b1);
        doReset(4'b1011, 1'b1);
        sendStream(32'b1011011, 7, 4'b1011, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'b1011, 1'b1);

        // Non-overlapping: 1,0,1,1,1,0,1,1 then 1,0,1,1,0,1,1
        doReset(4'b1011, 1'b0);
        sendStream(32'b10111011, 8, 4'b1011, 1'b0);
        doReset(4'b1011, 1'b0);
        sendStream(32'b1011011, 7, 4'b1011, 1'b0);

        // All-zero pattern right after reset needs four real zeros
        doReset(4'b0000, 1'b1);
        sendStream(32'b0000, 4, 4'b0000, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1);

        // Reset in the middle of a partial pattern discards it
        doReset(4'b1011, 1'b1);
        sendStream(32'b101, 3, 4'b1011, 1'b1);
        doReset(4'b1011, 1'b1);
        sendStream(32'b1011, 4, 4'b1011, 1'b1);
        sendStream(32'b1011, 4, 4'b1011, 1'b1);

        // Gaps in in_valid do not break the window or stretch y
        doReset(4'b1011, 1'b1);
        sendStream(32'b10, 2, 4'b1011, 1'b1);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 4'b1011, 1'b1);
        sendStream(32'b11, 2, 4'b1011, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 4'b1011, 1'b1);

        // All-ones with overlap: back-to-back pulses, counter saturates, clear keeps count
        doReset(4'b1111, 1'b1);
        sendStream(32'hFF, 8, 4'b1111, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 4'b1111, 1'b1);
        sendStream(32'b111, 3, 4'b1111, 1'b1);
        sendStream(32'b1, 1, 4'b1111, 1'b1);

        // Randomised traffic with occasional pattern/mode changes, clears and resets
        pat = LEN'($urandom);
        ovl = 1'($urandom);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) < 4) pat = LEN'($urandom);
            if ($urandom_range(0, 99) < 3) ovl = ~ovl;
            applyStimulus(($urandom_range(0, 99) >= 2),
                          ($urandom_range(0, 99) < 3),
                          ($urandom_range(0, 99) < 80),
                          1'($urandom), pat, ovl);
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, pat, ovl);

        // Drain the scoreboard with a bounded wait
        wait_cycles = 0;
        while (exp_q.size() > 0 && wait_cycles < 20) begin
            @(posedge clk);
            wait_cycles++;
        end
        #5;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain actual=%0d pending required=0 pending", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
